// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty measurement block.
package pwm_meas_pkg;

  typedef enum logic [1:0] {
    SEEK,
    HIGH,
    LOW
  } state_e;

  localparam int PWM_PERIOD = 2048;
  localparam int DUTY_W     = 11;
  localparam int CNT_W      = 12;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain for the asynchronous PWM input plus rise/fall detection.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic pwm_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pwm_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      pwm_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = pwm_s_o & ~pwm_d_q;
  assign fall_o  = ~pwm_s_o & pwm_d_q;

endmodule

// File: rtl/pwm11_meas.sv
// Recovers the duty word of a fixed-period PWM stream; one vld/err pulse per period.
// Build option PWM_MEAS_PERIOD_CHK_EN: reject periods whose length differs from PERIOD.
module pwm11_meas #(
  parameter int PERIOD      = pwm_meas_pkg::PWM_PERIOD,
  parameter int DUTY_W      = pwm_meas_pkg::DUTY_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PWM_sig,
  output logic [DUTY_W-1:0] duty,
  output logic              vld,
  output logic              err
);
  import pwm_meas_pkg::*;

  localparam int            CW    = DUTY_W + 1;
  localparam logic [CW-1:0] PER_C = CW'(PERIOD);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] DMAX  = CW'((2 ** DUTY_W) - 1);

  logic pwm_s, rise, fall;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .pwm_i   (PWM_sig),
    .pwm_s_o (pwm_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  state_e            state_q, state_d;
  logic [CW-1:0]     per_q, per_d, hi_q, hi_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              vld_q, vld_d, err_q, err_d;
  logic              tmo;

  function automatic logic [DUTY_W-1:0] sat_duty(input logic [CW-1:0] v);
    return (v > DMAX) ? DMAX[DUTY_W-1:0] : v[DUTY_W-1:0];
  endfunction

  assign tmo = (per_q == PER_C);

  always_comb begin
    state_d = state_q;
    per_d   = tmo ? per_q : per_q + ONE;
    hi_d    = hi_q;
    duty_d  = duty_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    if (rise) begin
      // Rise closes the previous period; counters still hold its values here.
      per_d   = ONE;
      hi_d    = ONE;
      state_d = HIGH;
      if (state_q == LOW) begin
`ifdef PWM_MEAS_PERIOD_CHK_EN
        if (tmo) begin
          duty_d = sat_duty(hi_q);
          vld_d  = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
`else
        duty_d = sat_duty(hi_q);
        vld_d  = 1'b1;
`endif
      end
    end else begin
      case (state_q)
        SEEK, LOW: begin
          // Only a genuinely low line reports duty 0; a high line left over
          // from a stuck-high event just restarts the timer.
          if (tmo) begin
            per_d = ONE;
            if (!pwm_s) begin
              hi_d   = '0;
              duty_d = '0;
              vld_d  = 1'b1;
            end
          end
        end
        HIGH: begin
          if (fall) begin
            state_d = LOW;
          end else if (tmo) begin
            err_d   = 1'b1;
            per_d   = ONE;
            state_d = SEEK;
          end else if (pwm_s && (hi_q != PER_C)) begin
            hi_d = hi_q + ONE;
          end
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEEK;
      per_q   <= '0;
      hi_q    <= '0;
      duty_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      hi_q    <= hi_d;
      duty_q  <= duty_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign duty = duty_q;
  assign vld  = vld_q;
  assign err  = err_q;

endmodule

// File: tb/tb_pwm11_meas.sv
// Directed bench for pwm11_meas: behavioural PWM generator plus hand-driven waveforms.
module tb_pwm11_meas;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PWM_sig = 1'b0;
  logic [10:0] duty;
  logic        vld;
  logic        err;

  pwm11_meas dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PWM_sig (PWM_sig),
    .duty    (duty),
    .vld     (vld),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vld_n = 0, err_n = 0, both_n = 0;
  int vld_cyc = 0, prev_vld_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    if (vld) begin
      vld_n        <= vld_n + 1;
      prev_vld_cyc <= vld_cyc;
      vld_cyc      <= cyc;
    end
    if (err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (vld && err) both_n <= both_n + 1;
  end

`ifdef PWM_MEAS_PERIOD_CHK_EN
  localparam int T5_DUTY = 500;
`else
  localparam int T5_DUTY = 300;
`endif

  int total = 0, bad = 0;
  int gen_cnt = 0, gen_duty = 0, gen_nxt = 0;
  bit gen_en = 1'b0;
  int v0, e0, r;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Generator: free-running 11-bit counter, duty latched at wrap.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (gen_en) begin
        gen_cnt = (gen_cnt + 1) % 2048;
        if (gen_cnt == 0) gen_duty = gen_nxt;
        PWM_sig = (gen_cnt < gen_duty);
      end
    end
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      PWM_sig = v;
    end
  endtask

  // Run to the next generator wrap, plus enough cycles to see its pulse.
  task automatic period_done();
    step(1);
    while (gen_cnt != 0) step(1);
    step(4);
  endtask

  initial begin
    // 1: reset with a toggling input
    for (int i = 0; i < 20; i++) drive(((i % 2) == 1), 1);
    chk("rst_duty", int'(duty), 0);
    chk("rst_vld", int'(vld), 0);
    chk("rst_err", int'(err), 0);
    drive(1'b0, 3);
    rst_n = 1'b1;
    gen_cnt = 2047; gen_duty = 0; gen_nxt = 1024; gen_en = 1'b1;
    v0 = vld_n; e0 = err_n;
    step(4);
    chk("t1_partial_vld", vld_n - v0, 0);
    chk("t1_partial_err", err_n - e0, 0);

    // 2: duty 1024 loopback
    period_done();
    chk("t2_first_vld", vld_n - v0, 1);
    chk("t2_first_duty", int'(duty), 1024);
    for (int i = 0; i < 3; i++) period_done();
    chk("t2_vld_count", vld_n - v0, 4);
    chk("t2_err_count", err_n - e0, 0);
    chk("t2_interval", vld_cyc - prev_vld_cyc, 2048);
    chk("t2_duty", int'(duty), 1024);

    // 3: duty 0 via the stuck-low path, then 2047
    gen_nxt = 0;
    v0 = vld_n; e0 = err_n;
    period_done();
    chk("t3_d0_vld", vld_n - v0, 1);
    chk("t3_d0_duty", int'(duty), 0);
    period_done();
    chk("t3_d0_vld2", vld_n - v0, 2);
    chk("t3_d0_interval", vld_cyc - prev_vld_cyc, 2048);
    chk("t3_d0_duty2", int'(duty), 0);
    gen_nxt = 2047;
    period_done();
    chk("t3_lowper_duty", int'(duty), 0);
    period_done();
    chk("t3_d2047_duty", int'(duty), 2047);
    chk("t3_vld_count", vld_n - v0, 4);
    chk("t3_err_count", err_n - e0, 0);

    // 4: duty 1, then step to 500 mid-period
    gen_nxt = 1;
    period_done();
    chk("t4_prev_2047", int'(duty), 2047);
    period_done();
    chk("t4_d1_duty", int'(duty), 1);
    step(1000);
    gen_nxt = 500;
    period_done();
    chk("t4_still_1", int'(duty), 1);
    period_done();
    chk("t4_d500_duty", int'(duty), 500);

    // 5: hand-driven period 1000 with 300 high cycles
    gen_en = 1'b0;
    v0 = vld_n; e0 = err_n;
    drive(1'b1, 295);
    drive(1'b0, 700);
    drive(1'b1, 1);
    r = cyc;
    drive(1'b1, 5);
`ifdef PWM_MEAS_PERIOD_CHK_EN
    chk("t5_err", err_n - e0, 1);
    chk("t5_vld", vld_n - v0, 0);
    chk("t5_err_latency", err_cyc - r, 3);
`else
    chk("t5_vld", vld_n - v0, 1);
    chk("t5_err", err_n - e0, 0);
    chk("t5_vld_latency", vld_cyc - r, 3);
`endif
    chk("t5_duty", int'(duty), T5_DUTY);

    // 6: stuck high for 3000 cycles after the rise
    v0 = vld_n; e0 = err_n;
    drive(1'b1, 2994);
    chk("t6_err", err_n - e0, 1);
    chk("t6_err_time", err_cyc - r, 2051);
    chk("t6_no_vld", vld_n - v0, 0);
    chk("t6_duty_hold", int'(duty), T5_DUTY);
    drive(1'b0, 100);
    drive(1'b1, 200);
    chk("t6_seek_no_vld", vld_n - v0, 0);
    chk("t6_seek_no_err", err_n - e0, 1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_duty", int'(duty), 0);
    chk("t6_rst_vld", int'(vld), 0);
    chk("t6_rst_err", int'(err), 0);
    drive(1'b1, 5);
    rst_n = 1'b1;
    v0 = vld_n; e0 = err_n;
    drive(1'b1, 50);
    drive(1'b0, 50);
    chk("t6_rel_vld", vld_n - v0, 0);
    chk("t6_rel_err", err_n - e0, 0);
    chk("t6_rel_duty", int'(duty), 0);
    chk("vld_err_overlap", both_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
